// File: rtl/id_exe_stage_pkg.sv
// Shared types for the ID/EXE pipeline register: ALU command
// encodings, NZCV flag indices and the stage control bundle.
package id_exe_stage_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef struct packed {
    logic s;
    logic mem_r;
    logic mem_w;
    logic wb_en;
    logic b;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic cmd_legal(
    input logic [3:0] cmd
  );
    logic ok;
    ok = 1'b0;
    unique case (cmd)
      CMD_MOV, CMD_MVN, CMD_ADD,
      CMD_ADC, CMD_SUB, CMD_SBC,
      CMD_AND, CMD_ORR, CMD_EOR:
        ok = 1'b1;
      default:
        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/id_exe_stage_status.sv
// status_register: 4-bit NZCV flag register with load enable.
// Ports: clk, rst_n (async, active low), ld_i, d_i[3:0], q_o[3:0].
module status_register (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_i,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] nzcv_q;
  logic [3:0] nzcv_d;

  always_comb begin
    nzcv_d = nzcv_q;
    if (ld_i) begin
      nzcv_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_q <= 4'b0000;
    end else begin
      nzcv_q <= nzcv_d;
    end
  end

  assign q_o = nzcv_q;

endmodule

// File: rtl/id_exe_stage.sv
// id_exe_stage: ID->EXE pipeline register plus NZCV status register.
// Inputs: clk, rst_n, freeze, flush, id_* instruction fields, alu_nzcv.
// Outputs: exe_* registered fields, exe_carry_in, status_nzcv,
// exe_illegal. Macro ID_EXE_FLUSH_EN enables the flush input;
// without it flush is ignored.
module id_exe_stage
  import id_exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_val1,
  input  logic [31:0] id_val2,
  input  logic [3:0]  id_cmd,
  input  logic        id_s,
  input  logic        id_mem_r,
  input  logic        id_mem_w,
  input  logic        id_wb_en,
  input  logic        id_b,
  input  logic [3:0]  id_dest,
  input  logic [31:0] id_pc,
  input  logic [3:0]  alu_nzcv,
  output logic        exe_valid,
  output logic [31:0] exe_val1,
  output logic [31:0] exe_val2,
  output logic [3:0]  exe_cmd,
  output logic        exe_s,
  output logic        exe_mem_r,
  output logic        exe_mem_w,
  output logic        exe_wb_en,
  output logic        exe_b,
  output logic [3:0]  exe_dest,
  output logic [31:0] exe_pc,
  output logic        exe_carry_in,
  output logic [3:0]  status_nzcv,
  output logic        exe_illegal
);

  logic flush_eff;

`ifdef ID_EXE_FLUSH_EN
  assign flush_eff = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_eff = 1'b0;
`endif

  logic        valid_q,   valid_d;
  logic [31:0] val1_q,    val1_d;
  logic [31:0] val2_q,    val2_d;
  logic [3:0]  cmd_q,     cmd_d;
  ctrl_t       ctrl_q,    ctrl_d;
  logic [3:0]  dest_q,    dest_d;
  logic [31:0] pc_q,      pc_d;
  logic        illegal_q, illegal_d;

  ctrl_t id_ctrl;
  logic  id_bad;

  assign id_ctrl = '{
    s:     id_s,
    mem_r: id_mem_r,
    mem_w: id_mem_w,
    wb_en: id_wb_en,
    b:     id_b
  };

  assign id_bad = !cmd_legal(id_cmd);

  always_comb begin
    valid_d   = valid_q;
    val1_d    = val1_q;
    val2_d    = val2_q;
    cmd_d     = cmd_q;
    ctrl_d    = ctrl_q;
    dest_d    = dest_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    unique case (1'b1)
      freeze: begin
      end
      (flush_eff || !id_valid): begin
        valid_d   = 1'b0;
        val1_d    = '0;
        val2_d    = '0;
        cmd_d     = '0;
        ctrl_d    = CTRL_NONE;
        dest_d    = '0;
        pc_d      = '0;
        illegal_d = 1'b0;
      end
      default: begin
        valid_d   = 1'b1;
        val1_d    = id_val1;
        val2_d    = id_val2;
        cmd_d     = id_cmd;
        ctrl_d    = id_ctrl;
        dest_d    = id_dest;
        pc_d      = id_pc;
        illegal_d = id_bad;
        // An undefined command must not write any state.
        if (id_bad) begin
          ctrl_d.s     = 1'b0;
          ctrl_d.mem_r = 1'b0;
          ctrl_d.mem_w = 1'b0;
          ctrl_d.wb_en = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      val1_q    <= '0;
      val2_q    <= '0;
      cmd_q     <= '0;
      ctrl_q    <= CTRL_NONE;
      dest_q    <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      val1_q    <= val1_d;
      val2_q    <= val2_d;
      cmd_q     <= cmd_d;
      ctrl_q    <= ctrl_d;
      dest_q    <= dest_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
    end
  end

  // Flags retire on the same edge the next instruction loads,
  // so that instruction sees the new carry.
  logic status_ld;
  assign status_ld = valid_q && ctrl_q.s && !freeze;

  status_register u_status (
    .clk   (clk),
    .rst_n (rst_n),
    .ld_i  (status_ld),
    .d_i   (alu_nzcv),
    .q_o   (status_nzcv)
  );

  assign exe_carry_in = status_nzcv[NZCV_C];

  assign exe_valid   = valid_q;
  assign exe_val1    = val1_q;
  assign exe_val2    = val2_q;
  assign exe_cmd     = cmd_q;
  assign exe_s       = ctrl_q.s;
  assign exe_mem_r   = ctrl_q.mem_r;
  assign exe_mem_w   = ctrl_q.mem_w;
  assign exe_wb_en   = ctrl_q.wb_en;
  assign exe_b       = ctrl_q.b;
  assign exe_dest    = dest_q;
  assign exe_pc      = pc_q;
  assign exe_illegal = illegal_q;

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed testbench for id_exe_stage.
// Covers reset, load, flags, freeze, illegal, flush and mid-run reset.
module tb_id_exe_stage;

  logic        clk;
  logic        rst_n;
  logic        freeze;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_val1;
  logic [31:0] id_val2;
  logic [3:0]  id_cmd;
  logic        id_s;
  logic        id_mem_r;
  logic        id_mem_w;
  logic        id_wb_en;
  logic        id_b;
  logic [3:0]  id_dest;
  logic [31:0] id_pc;
  logic [3:0]  alu_nzcv;
  logic        exe_valid;
  logic [31:0] exe_val1;
  logic [31:0] exe_val2;
  logic [3:0]  exe_cmd;
  logic        exe_s;
  logic        exe_mem_r;
  logic        exe_mem_w;
  logic        exe_wb_en;
  logic        exe_b;
  logic [3:0]  exe_dest;
  logic [31:0] exe_pc;
  logic        exe_carry_in;
  logic [3:0]  status_nzcv;
  logic        exe_illegal;

  int tests;
  int fails;

  id_exe_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freeze       (freeze),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_val1      (id_val1),
    .id_val2      (id_val2),
    .id_cmd       (id_cmd),
    .id_s         (id_s),
    .id_mem_r     (id_mem_r),
    .id_mem_w     (id_mem_w),
    .id_wb_en     (id_wb_en),
    .id_b         (id_b),
    .id_dest      (id_dest),
    .id_pc        (id_pc),
    .alu_nzcv     (alu_nzcv),
    .exe_valid    (exe_valid),
    .exe_val1     (exe_val1),
    .exe_val2     (exe_val2),
    .exe_cmd      (exe_cmd),
    .exe_s        (exe_s),
    .exe_mem_r    (exe_mem_r),
    .exe_mem_w    (exe_mem_w),
    .exe_wb_en    (exe_wb_en),
    .exe_b        (exe_b),
    .exe_dest     (exe_dest),
    .exe_pc       (exe_pc),
    .exe_carry_in (exe_carry_in),
    .status_nzcv  (status_nzcv),
    .exe_illegal  (exe_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic       v,
                       input logic [3:0] cmd,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic       s,
                       input logic       wb,
                       input logic [3:0] dest,
                       input logic [31:0] pc);
    id_valid = v;
    id_cmd   = cmd;
    id_val1  = a;
    id_val2  = b;
    id_s     = s;
    id_wb_en = wb;
    id_dest  = dest;
    id_pc    = pc;
    id_mem_r = 1'b0;
    id_mem_w = 1'b0;
    id_b     = 1'b0;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    freeze   = 1'b0;
    flush    = 1'b0;
    alu_nzcv = 4'b0000;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
    #1;
    chk("rst_valid", 32'(exe_valid), 32'h0);
    chk("rst_status", 32'(status_nzcv), 32'h0);
    chk("rst_carry", 32'(exe_carry_in), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load an ADD with S set
    drive(1'b1, 4'b0010, 32'd5, 32'd7, 1'b1, 1'b1, 4'd3, 32'h100);
    step();
    chk("ld_valid", 32'(exe_valid), 32'h1);
    chk("ld_val1", exe_val1, 32'd5);
    chk("ld_val2", exe_val2, 32'd7);
    chk("ld_cmd", 32'(exe_cmd), 32'h2);
    chk("ld_wb", 32'(exe_wb_en), 32'h1);
    chk("ld_dest", 32'(exe_dest), 32'd3);
    chk("ld_pc", exe_pc, 32'h100);
    chk("ld_ill", 32'(exe_illegal), 32'h0);
    chk("ld_status", 32'(status_nzcv), 32'h0);

    // ALU reports carry; ADC follows
    alu_nzcv = 4'b0010;
    drive(1'b1, 4'b0011, 32'd1, 32'd2, 1'b0, 1'b1, 4'd4, 32'h104);
    step();
    chk("flg_status", 32'(status_nzcv), 32'h2);
    chk("flg_carry", 32'(exe_carry_in), 32'h1);
    chk("flg_cmd", 32'(exe_cmd), 32'h3);

    // SUB with S enters EXE (ADC had S=0: no update)
    alu_nzcv = 4'b1000;
    drive(1'b1, 4'b0100, 32'd9, 32'd3, 1'b1, 1'b1, 4'd5, 32'h108);
    step();
    chk("sub_status", 32'(status_nzcv), 32'h2);
    chk("sub_dest", 32'(exe_dest), 32'd5);

    // Freeze three cycles
    freeze = 1'b1;
    drive(1'b1, 4'b0001, 32'd6, 32'd0, 1'b0, 1'b1, 4'd6, 32'h10c);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_dest", 32'(exe_dest), 32'd5);
      chk("frz_cmd", 32'(exe_cmd), 32'h4);
      chk("frz_status", 32'(status_nzcv), 32'h2);
    end
    freeze = 1'b0;
    step();
    chk("rel_status", 32'(status_nzcv), 32'h8);
    chk("rel_carry", 32'(exe_carry_in), 32'h0);
    chk("rel_dest", 32'(exe_dest), 32'd6);

    // id_valid low loads a bubble
    drive(1'b0, 4'b0010, 32'd1, 32'd1, 1'b1, 1'b1, 4'd7, 32'h110);
    step();
    chk("bub_valid", 32'(exe_valid), 32'h0);
    chk("bub_wb", 32'(exe_wb_en), 32'h0);
    chk("bub_s", 32'(exe_s), 32'h0);
    chk("bub_status", 32'(status_nzcv), 32'h8);

    // Illegal command 1111
    alu_nzcv = 4'b0101;
    drive(1'b1, 4'b1111, 32'd1, 32'd1, 1'b1, 1'b1, 4'd8, 32'h114);
    step();
    chk("ill_flag", 32'(exe_illegal), 32'h1);
    chk("ill_wb", 32'(exe_wb_en), 32'h0);
    chk("ill_s", 32'(exe_s), 32'h0);
    chk("ill_valid", 32'(exe_valid), 32'h1);

    // Illegal command 0000
    drive(1'b1, 4'b0000, 32'd2, 32'd2, 1'b0, 1'b1, 4'd9, 32'h118);
    step();
    chk("ill_status", 32'(status_nzcv), 32'h8);
    chk("ill0_flag", 32'(exe_illegal), 32'h1);

    // Legal MVN clears illegal
    drive(1'b1, 4'b1001, 32'd3, 32'd3, 1'b0, 1'b1, 4'd10, 32'h11c);
    step();
    chk("mvn_ill", 32'(exe_illegal), 32'h0);
    chk("mvn_wb", 32'(exe_wb_en), 32'h1);

    // Flush
    flush = 1'b1;
    drive(1'b1, 4'b0010, 32'hAA, 32'hBB, 1'b0, 1'b1, 4'd11, 32'h120);
    step();
`ifdef ID_EXE_FLUSH_EN
    chk("fl_valid", 32'(exe_valid), 32'h0);
    chk("fl_wb", 32'(exe_wb_en), 32'h0);
    chk("fl_val1", exe_val1, 32'h0);
`else
    chk("fl_valid", 32'(exe_valid), 32'h1);
    chk("fl_wb", 32'(exe_wb_en), 32'h1);
    chk("fl_val1", exe_val1, 32'hAA);
`endif

    // Freeze beats flush
    flush = 1'b0;
    drive(1'b1, 4'b0110, 32'h33, 32'h44, 1'b0, 1'b1, 4'd12, 32'h124);
    step();
    freeze = 1'b1;
    flush  = 1'b1;
    drive(1'b1, 4'b0111, 32'h55, 32'h66, 1'b1, 1'b1, 4'd13, 32'h128);
    step();
    chk("ff_valid", 32'(exe_valid), 32'h1);
    chk("ff_dest", 32'(exe_dest), 32'd12);
    chk("ff_val1", exe_val1, 32'h33);
    chk("ff_status", 32'(status_nzcv), 32'h8);
    freeze = 1'b0;
    flush  = 1'b0;

    // Mid-cycle reset
    drive(1'b1, 4'b1000, 32'h77, 32'h88, 1'b1, 1'b1, 4'd14, 32'h12c);
    step();
    chk("pre_valid", 32'(exe_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(exe_valid), 32'h0);
    chk("mr_val1", exe_val1, 32'h0);
    chk("mr_wb", 32'(exe_wb_en), 32'h0);
    chk("mr_status", 32'(status_nzcv), 32'h0);
    chk("mr_carry", 32'(exe_carry_in), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    alu_nzcv = 4'b1111;
    drive(1'b1, 4'b0010, 32'd21, 32'd22, 1'b0, 1'b1, 4'd2, 32'h200);
    step();
    chk("post_valid", 32'(exe_valid), 32'h1);
    chk("post_val1", exe_val1, 32'd21);
    chk("post_status", 32'(status_nzcv), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
